// File: rtl/power_manager_pkg.sv
// Shared encodings for the power manager and the power block it controls.
package power_manager_pkg;

  typedef logic [1:0] pm_state_t;

  localparam pm_state_t ST_OFF      = 2'd0;
  localparam pm_state_t ST_RUN      = 2'd1;
  localparam pm_state_t ST_THROTTLE = 2'd2;
  localparam pm_state_t ST_CHARGE   = 2'd3;

  localparam logic [1:0] SET_OFF  = 2'd0;
  localparam logic [1:0] SET_LOW  = 2'd1;
  localparam logic [1:0] SET_MOD  = 2'd2;
  localparam logic [1:0] SET_HIGH = 2'd3;

  localparam logic MODE_RECHARGE = 1'b0;
  localparam logic MODE_USE      = 1'b1;

  localparam int unsigned MAX_LEVEL_DEFAULT = 179;
  localparam int unsigned WARN_LEVEL        = 45;

  // Usage allowed while throttled: never above low.
  function automatic logic [1:0] throttle_setting(input logic [1:0] demand);
    return (demand > SET_LOW) ? SET_LOW : demand;
  endfunction

endpackage

// File: rtl/power_manager_if.sv
// Control/status bundle between the user side, the power manager and the power block.
// Stats outputs exist only when POWER_MGR_STATS_EN is defined.
interface power_manager_if #(
  parameter int unsigned LEVEL_W = 8
);
  logic               enable;
  logic [1:0]         demand;
  logic [LEVEL_W-1:0] power_level;
  logic               power_warn;
  logic               power_en;
  logic [1:0]         power_setting;
  logic               power_mode;
  logic [1:0]         state;
  logic               throttled;
  logic               charging;
`ifdef POWER_MGR_STATS_EN
  logic [7:0]         charge_events;
  logic [7:0]         throttle_events;
`endif

  modport master (
    output enable, demand, power_level, power_warn,
    input  power_en, power_setting, power_mode, state, throttled, charging
`ifdef POWER_MGR_STATS_EN
    , input charge_events, throttle_events
`endif
  );

  modport slave (
    input  enable, demand, power_level, power_warn,
    output power_en, power_setting, power_mode, state, throttled, charging
`ifdef POWER_MGR_STATS_EN
    , output charge_events, throttle_events
`endif
  );

endinterface

// File: rtl/pm_dwell_counter.sv
// Counts consecutive increment cycles up to DWELL (saturating); done_o flags the DWELL-th one.
module pm_dwell_counter #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic done_o
);

  logic [3:0] cnt_q, cnt_d;

  assign done_o = inc_i && (cnt_q == 4'(DWELL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < 4'(DWELL))) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/power_manager.sv
// Power manager FSM: arbitrates user demand against charge, throttles on warning,
// forces recharge on depletion. Optional event counters with POWER_MGR_STATS_EN.
module power_manager
  import power_manager_pkg::*;
#(
  parameter int unsigned LEVEL_W      = 8,
  parameter int unsigned MAX_LEVEL    = MAX_LEVEL_DEFAULT,
  parameter int unsigned RESUME_LEVEL = 90,
  parameter int unsigned DWELL        = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  power_manager_if.slave bus
);

  pm_state_t  state_q, state_d;
  logic       en_q, en_d, mode_q, mode_d, thr_q, thr_d, chg_q, chg_d;
  logic [1:0] setting_q, setting_d;
  logic       depleted, full, dwell_inc, dwell_clr, dwell_done;

  // Moderate/high demand needs at least `demand` seconds of charge left.
  assign depleted = (bus.power_level == '0) ||
                    (bus.demand[1] && (bus.power_level < LEVEL_W'(bus.demand)));
  assign full     = bus.power_level >= LEVEL_W'(MAX_LEVEL);

  assign dwell_inc = (state_q == ST_THROTTLE) && !bus.power_warn;
  assign dwell_clr = (state_q != ST_THROTTLE) || bus.power_warn || dwell_done ||
                     !bus.enable || depleted;

  pm_dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (dwell_clr),
    .inc_i  (dwell_inc),
    .done_o (dwell_done)
  );

  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = ST_OFF;
    end else if (depleted) begin
      state_d = ST_CHARGE;
    end else begin
      case (state_q)
        ST_OFF:      state_d = ST_RUN;
        ST_RUN:      if (bus.power_warn) state_d = ST_THROTTLE;
        ST_THROTTLE: if (dwell_done) state_d = ST_RUN;
        ST_CHARGE: begin
          if ((bus.power_level >= LEVEL_W'(RESUME_LEVEL)) && (bus.demand != SET_OFF)) begin
            state_d = ST_RUN;
          end
        end
        default:     state_d = ST_OFF;
      endcase
    end
  end

  // Outputs follow the next state so they land together with it.
  always_comb begin
    en_d      = 1'b0;
    mode_d    = MODE_RECHARGE;
    setting_d = SET_OFF;
    thr_d     = 1'b0;
    chg_d     = 1'b0;
    case (state_d)
      ST_RUN: begin
        en_d      = 1'b1;
        mode_d    = MODE_USE;
        setting_d = bus.demand;
      end
      ST_THROTTLE: begin
        en_d      = 1'b1;
        mode_d    = MODE_USE;
        setting_d = throttle_setting(bus.demand);
        thr_d     = 1'b1;
      end
      ST_CHARGE: begin
        en_d      = 1'b1;
        setting_d = full ? SET_OFF : SET_LOW;
        chg_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_OFF;
      en_q      <= 1'b0;
      mode_q    <= 1'b0;
      setting_q <= '0;
      thr_q     <= 1'b0;
      chg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      setting_q <= setting_d;
      thr_q     <= thr_d;
      chg_q     <= chg_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.power_en      = en_q;
  assign bus.power_mode    = mode_q;
  assign bus.power_setting = setting_q;
  assign bus.throttled     = thr_q;
  assign bus.charging      = chg_q;

`ifdef POWER_MGR_STATS_EN
  logic [7:0] chg_ev_q, thr_ev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chg_ev_q <= '0;
      thr_ev_q <= '0;
    end else begin
      if ((state_d == ST_CHARGE) && (state_q != ST_CHARGE) && (chg_ev_q != 8'hFF)) begin
        chg_ev_q <= chg_ev_q + 8'd1;
      end
      if ((state_d == ST_THROTTLE) && (state_q != ST_THROTTLE) && (thr_ev_q != 8'hFF)) begin
        thr_ev_q <= thr_ev_q + 8'd1;
      end
    end
  end

  assign bus.charge_events   = chg_ev_q;
  assign bus.throttle_events = thr_ev_q;
`endif

endmodule

// File: doc/power_manager.md
Name: power_manager

Overview:
- Control-side counterpart of the power block. Consumes the tracked power level and low-power warning, and drives that block's enable, usage setting and mode (recharge/use).
- Arbitrates a user usage demand against available charge.
  - Throttles usage under warning.
  - Forces a recharge cycle on depletion.
  - Resumes usage once the level recovers.
- Sits between the user-facing controls and the power block.

Parameters:
- LEVEL_W, 8, width of the power level in seconds.
- MAX_LEVEL, 179, full-charge bound; at or above it, charging holds with setting 0.
- RESUME_LEVEL, 90, level at which CHARGE may exit back to RUN.
- DWELL, 4, consecutive cycles with power_warn low before THROTTLE returns to RUN (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  system power switch.
- demand  in  2  requested usage setting: 0 off, 1 low, 2 moderate, 3 high.
- power_level  in  LEVEL_W  current level from the power block.
- power_warn  in  1  low-level warning from the power block.
- power_en  out  1  enable to the power block.
- power_setting  out  2  setting to the power block.
- power_mode  out  1  0 = recharge, 1 = use.
- state  out  2  0 OFF, 1 RUN, 2 THROTTLE, 3 CHARGE.
- throttled  out  1  high in THROTTLE.
- charging  out  1  high in CHARGE.

Behaviour:
- Reset value of every output: 0. The clock is clk; the reset is rst, asynchronous and active-low. The dwell counter resets to 0 and the state resets to OFF.
- All outputs are registered and are a function of the next state and current inputs. Input-to-output latency is 1 cycle.
- Transition priority, highest first: enable=0, then depletion, then state-specific rules.
- Depletion = power_level==0, or power_level < demand with demand in {2,3}.
- OFF: power_en=0, setting=0, mode=0.
  - enable=1 and power_level==0 -> CHARGE.
  - enable=1 otherwise -> RUN.
- RUN: power_en=1, mode=1, setting=demand.
  - Depletion -> CHARGE.
  - Otherwise power_warn=1 -> THROTTLE; dwell counter cleared.
- THROTTLE: power_en=1, mode=1, setting=min(demand,1), throttled=1.
  - Depletion -> CHARGE.
  - Dwell counter increments each cycle power_warn=0 and clears on power_warn=1.
  - Counter reaching DWELL -> RUN; counter cleared.
- CHARGE: power_en=1, mode=0, charging=1.
  - setting=1 while power_level < MAX_LEVEL, else 0 (hold at full).
  - power_level >= RESUME_LEVEL and demand!=0 -> RUN.
  - demand==0 -> remain in CHARGE, including once full.
- enable=0 from any state -> OFF on the next edge; the dwell counter clears.
- A demand change in RUN is reflected on power_setting one cycle later. No re-entry of THROTTLE is needed for demand changes.
- power_level is treated as unsigned. Values above MAX_LEVEL are treated as full.
- Reset asserted mid-operation -> all outputs 0 immediately (asynchronous). The first state after release is OFF.

Optional Feature:
- Macro: POWER_MGR_STATS_EN.
- With the macro defined, two extra outputs are added:
  - charge_events[7:0]: increments on each entry into CHARGE and saturates at 255.
  - throttle_events[7:0]: increments on each entry into THROTTLE and saturates at 255.
  - Both reset to 0 on rst.
  - Neither is cleared by enable=0.
- Without the macro: these ports and counters are absent, and core behaviour is identical.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_OFF=0, ST_RUN=1, ST_THROTTLE=2, ST_CHARGE=3.
  - Setting constants: SET_OFF..SET_HIGH = 0..3.
  - Mode constants: MODE_RECHARGE=0, MODE_USE=1.
  - Default MAX_LEVEL = 179 and warn threshold 45, shared with the power block.
- One sub-module is natural: pm_dwell_counter, a saturating count-to-DWELL counter with clear and a done flag. The FSM, output registers and stats stay in the top.

Test Plan:
- Reset/enable: rst low then high, enable=1, power_level=100, demand=3 -> state RUN, power_en=1, mode=1, setting=3 one cycle after enable.
- Throttle: in RUN, demand=2, power_warn rises -> next cycle state THROTTLE, setting=1, throttled=1. power_warn low for 3 cycles then high for 1 -> stays THROTTLE. Low for 4 cycles -> RUN, setting=2.
- Depletion: in RUN, demand=3, power_level drops to 2 -> CHARGE, mode=0, setting=1, charging=1. power_level 89 -> stays CHARGE. 90 -> RUN, setting=3.
- Full hold: in CHARGE, demand=0, power_level=179 -> stays CHARGE, setting=0, mode=0.
- Async reset/disable: mid-CHARGE assert rst between edges -> all outputs 0 immediately. After release, enable=0 -> OFF persists. Later, enable low while in RUN -> OFF next edge, power_en=0.
- POWER_MGR_STATS_EN: three forced depletions and two warn events -> charge_events=3, throttle_events=2. Charge events held at 255 -> no wrap.
